// File: rtl/rtc_disp_pkg.sv
// Shared definitions for the RTC text renderer: glyph codes, glyph geometry,
// active-area size, edit-field encodings and the 8x16 font bitmap function.
// The font is a seven-segment style digit set plus colon, slash and blank.
package rtc_disp_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int SCALE   = 2;

    localparam logic [9:0] ACTIVE_W = 10'd640;
    localparam logic [9:0] ACTIVE_H = 10'd480;

    localparam logic [3:0] GLYPH_COLON = 4'd10;
    localparam logic [3:0] GLYPH_SLASH = 4'd11;
    localparam logic [3:0] GLYPH_BLANK = 4'd12;

    typedef enum logic [2:0] {
        EDIT_NONE  = 3'd0,
        EDIT_HH    = 3'd1,
        EDIT_MM    = 3'd2,
        EDIT_SS    = 3'd3,
        EDIT_DD    = 3'd4,
        EDIT_MO    = 3'd5,
        EDIT_YY    = 3'd6,
        EDIT_NONE7 = 3'd7
    } edit_sel_e;

    // Row byte of a glyph, MSB is the leftmost pixel. Digits are drawn from a
    // segment mask {a,b,c,d,e,f,g}; horizontal bars span columns 1-6 and
    // vertical bars are two pixels wide at columns 1-2 (left) and 5-6 (right).
    function automatic logic [7:0] font_row(input logic [3:0] code, input logic [3:0] row);
        logic [6:0] seg;
        logic [7:0] bits;
        bits = 8'h00;
        case (code)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        if (code <= 4'd9) begin
            case (row)
                4'd1, 4'd2:               bits = seg[6] ? 8'h7E : 8'h00;
                4'd3, 4'd4, 4'd5, 4'd6:   bits = (seg[1] ? 8'h60 : 8'h00) | (seg[5] ? 8'h06 : 8'h00);
                4'd7, 4'd8:               bits = seg[0] ? 8'h7E : 8'h00;
                4'd9, 4'd10, 4'd11, 4'd12: bits = (seg[2] ? 8'h60 : 8'h00) | (seg[4] ? 8'h06 : 8'h00);
                4'd13, 4'd14:             bits = seg[3] ? 8'h7E : 8'h00;
                default:                  bits = 8'h00;
            endcase
        end else if (code == GLYPH_COLON) begin
            if (row == 4'd4 || row == 4'd5 || row == 4'd10 || row == 4'd11) begin
                bits = 8'h18;
            end
        end else if (code == GLYPH_SLASH) begin
            // Rising diagonal: rightmost at the top, one column per two rows.
            if (row >= 4'd1 && row <= 4'd14) begin
                bits = 8'h01 << ((row - 4'd1) >> 1);
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/rtc_text_render_font_rom.sv
// Synchronous-read glyph ROM.
// Ports: clk, rst (async active-low), en (read enable, holds output when 0),
// code (4-bit glyph code), row (4-bit glyph row), row_byte (registered bitmap row).
module font_rom
    import rtc_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] code,
    input  logic [3:0] row,
    output logic [7:0] row_byte
);

    logic [7:0] row_byte_d;
    logic [7:0] row_byte_q;

    always_comb begin
        row_byte_d = row_byte_q;
        if (en) begin
            row_byte_d = font_row(code, row);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_byte_q <= 8'h00;
        end else begin
            row_byte_q <= row_byte_d;
        end
    end

    assign row_byte = row_byte_q;

endmodule

// File: rtl/rtc_text_render.sv
// RTC text renderer: draws "HH:MM:SS" and "DD/MM/YY" as 2x-scaled 8x16 glyphs
// behind the VGA sync generator, blinking the field under edit.
// Ports: clk, rst (async active-low), px_en/px_x/px_y/hsync_in/vsync_in from the
// sync generator, BCD time/date inputs, edit_sel; outputs rgb (RRRGGGBB),
// hsync_out/vsync_out aligned with rgb, frame_tick (one clk at frame start).
module rtc_text_render
    import rtc_disp_pkg::*;
#(
    parameter logic [9:0] X0        = 10'd256,
    parameter logic [9:0] Y_TIME    = 10'd192,
    parameter logic [9:0] Y_DATE    = 10'd256,
    parameter logic [7:0] FG        = 8'hFF,
    parameter logic [7:0] BG        = 8'h03,
    parameter int         BLINK_BIT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       px_en,
    input  logic [9:0] px_x,
    input  logic [9:0] px_y,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic [7:0] dd,
    input  logic [7:0] mo,
    input  logic [7:0] yy,
    input  logic [2:0] edit_sel,
    output logic [7:0] rgb,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       frame_tick
);

    localparam logic [9:0] ROW_W = 10'(8 * GLYPH_W * SCALE);
    localparam logic [9:0] ROW_H = 10'(GLYPH_H * SCALE);

    // Frame-level state
    logic       frame_start;
    logic [7:0] frame_cnt_d, frame_cnt_q;
    logic       frame_tick_d, frame_tick_q;
    logic [7:0] hh_d, hh_q, mm_d, mm_q, ss_d, ss_q;
    logic [7:0] dd_d, dd_q, mo_d, mo_q, yy_d, yy_q;

    // Stage 1 combinational decode
    logic [9:0] dx, dy_time, dy_date;
    logic       in_active, col_hit, time_hit, date_hit;
    logic [2:0] char_idx, gcol;
    logic [3:0] grow;
    logic       is_sep, lo_digit, blanked;
    logic [1:0] slot;
    logic [7:0] field_val;
    logic [2:0] field_id;
    logic [3:0] nibble, glyph_code;
    logic       unused_bits;

    // Stage registers
    logic       hit_d, hit_q, active_d, active_q;
    logic [2:0] gcol_d, gcol_q;
    logic       hsync1_d, hsync1_q, vsync1_d, vsync1_q;
    logic [7:0] rgb_d, rgb_q;
    logic       hsync2_d, hsync2_q, vsync2_d, vsync2_q;
    logic [7:0] rom_byte;
    logic       glyph_bit;

    // Shadow capture and frame counter update at the frame-start pixel so the
    // displayed values can only change during vertical blanking.
    always_comb begin
        frame_start  = px_en && (px_x == 10'd0) && (px_y == ACTIVE_H);
        frame_tick_d = frame_start;
        frame_cnt_d  = frame_cnt_q;
        hh_d = hh_q; mm_d = mm_q; ss_d = ss_q;
        dd_d = dd_q; mo_d = mo_q; yy_d = yy_q;
        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            hh_d = hh; mm_d = mm; ss_d = ss;
            dd_d = dd; mo_d = mo; yy_d = yy;
        end
    end

    // Stage 1: locate the pixel within a text row and pick its glyph. Character
    // slots 2 and 5 are separators; the rest map pairwise onto three BCD fields.
    always_comb begin
        dx        = px_x - X0;
        dy_time   = px_y - Y_TIME;
        dy_date   = px_y - Y_DATE;
        in_active = (px_x < ACTIVE_W) && (px_y < ACTIVE_H);
        col_hit   = (px_x >= X0) && (px_x < X0 + ROW_W);
        time_hit  = col_hit && (px_y >= Y_TIME) && (px_y < Y_TIME + ROW_H);
        date_hit  = col_hit && (px_y >= Y_DATE) && (px_y < Y_DATE + ROW_H);
        char_idx  = dx[6:4];
        gcol      = dx[3:1];
        grow      = date_hit ? dy_date[4:1] : dy_time[4:1];

        is_sep   = 1'b0;
        slot     = 2'd0;
        lo_digit = 1'b0;
        case (char_idx)
            3'd0:    begin slot = 2'd0; lo_digit = 1'b0; end
            3'd1:    begin slot = 2'd0; lo_digit = 1'b1; end
            3'd3:    begin slot = 2'd1; lo_digit = 1'b0; end
            3'd4:    begin slot = 2'd1; lo_digit = 1'b1; end
            3'd6:    begin slot = 2'd2; lo_digit = 1'b0; end
            3'd7:    begin slot = 2'd2; lo_digit = 1'b1; end
            default: is_sep = 1'b1;
        endcase

        if (date_hit) begin
            field_val = (slot == 2'd0) ? dd_q : (slot == 2'd1) ? mo_q : yy_q;
            field_id  = EDIT_DD + {1'b0, slot};
        end else begin
            field_val = (slot == 2'd0) ? hh_q : (slot == 2'd1) ? mm_q : ss_q;
            field_id  = EDIT_HH + {1'b0, slot};
        end
        nibble  = lo_digit ? field_val[3:0] : field_val[7:4];
        blanked = (edit_sel == field_id) && !frame_cnt_q[BLINK_BIT];

        if (is_sep) begin
            glyph_code = date_hit ? GLYPH_SLASH : GLYPH_COLON;
        end else if (blanked || (nibble > 4'd9)) begin
            glyph_code = GLYPH_BLANK;
        end else begin
            glyph_code = nibble;
        end

        unused_bits = ^{dx[9:7], dx[0], dy_time[9:5], dy_time[0], dy_date[9:5], dy_date[0]};
    end

    // The ROM is addressed straight from the stage-1 decode so its output
    // register sits alongside the stage-1 flops; the column-bit select then
    // lands in the rgb register, giving two strobes of total latency.
    font_rom u_font_rom (
        .clk      (clk),
        .rst      (rst),
        .en       (px_en),
        .code     (glyph_code),
        .row      (grow),
        .row_byte (rom_byte)
    );

    // Both stages hold whenever the pixel strobe is low.
    always_comb begin
        hit_d    = hit_q;
        active_d = active_q;
        gcol_d   = gcol_q;
        hsync1_d = hsync1_q;
        vsync1_d = vsync1_q;
        rgb_d    = rgb_q;
        hsync2_d = hsync2_q;
        vsync2_d = vsync2_q;
        glyph_bit = rom_byte[3'd7 - gcol_q];
        if (px_en) begin
            hit_d    = time_hit || date_hit;
            active_d = in_active;
            gcol_d   = gcol;
            hsync1_d = hsync_in;
            vsync1_d = vsync_in;
            if (!active_q) begin
                rgb_d = 8'h00;
            end else if (hit_q && glyph_bit) begin
                rgb_d = FG;
            end else begin
                rgb_d = BG;
            end
            hsync2_d = hsync1_q;
            vsync2_d = vsync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q  <= 8'd0;
            frame_tick_q <= 1'b0;
            hh_q <= 8'd0; mm_q <= 8'd0; ss_q <= 8'd0;
            dd_q <= 8'd0; mo_q <= 8'd0; yy_q <= 8'd0;
            hit_q    <= 1'b0;
            active_q <= 1'b0;
            gcol_q   <= 3'd0;
            hsync1_q <= 1'b1;
            vsync1_q <= 1'b1;
            rgb_q    <= 8'h00;
            hsync2_q <= 1'b1;
            vsync2_q <= 1'b1;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            frame_tick_q <= frame_tick_d;
            hh_q <= hh_d; mm_q <= mm_d; ss_q <= ss_d;
            dd_q <= dd_d; mo_q <= mo_d; yy_q <= yy_d;
            hit_q    <= hit_d;
            active_q <= active_d;
            gcol_q   <= gcol_d;
            hsync1_q <= hsync1_d;
            vsync1_q <= vsync1_d;
            rgb_q    <= rgb_d;
            hsync2_q <= hsync2_d;
            vsync2_q <= vsync2_d;
        end
    end

    assign rgb        = rgb_q;
    assign hsync_out  = hsync2_q;
    assign vsync_out  = vsync2_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_rtc_text_render.sv
// Self-checking bench for rtc_text_render: drives pixel coordinates directly
// (no full raster scan) and compares every output after every clock against a
// behavioural model that builds each text row as a string of glyph codes.
module tb_rtc_text_render;
    import rtc_disp_pkg::font_row;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       px_en = 1'b0;
    logic [9:0] px_x = 10'd0, px_y = 10'd0;
    logic       hsync_in = 1'b1, vsync_in = 1'b1;
    logic [7:0] hh = 8'h00, mm = 8'h00, ss = 8'h00;
    logic [7:0] dd = 8'h00, mo = 8'h00, yy = 8'h00;
    logic [2:0] edit_sel = 3'd0;
    logic [7:0] rgb;
    logic       hsync_out, vsync_out, frame_tick;

    int checks = 0;
    int errors = 0;

    // Model state: shadowed BCD values, frame counter, and the two pipeline slots
    // holding {rgb, hsync, vsync}.
    logic [7:0] mSh [6];
    logic [7:0] mCnt;
    logic [9:0] pipe1, outExp;
    logic       tickExp;

    rtc_text_render dut (
        .clk        (clk),
        .rst        (rst),
        .px_en      (px_en),
        .px_x       (px_x),
        .px_y       (px_y),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss),
        .dd         (dd),
        .mo         (mo),
        .yy         (yy),
        .edit_sel   (edit_sel),
        .rgb        (rgb),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h (x=%0d y=%0d t=%0t)",
                     tag, observed, expected, px_x, px_y, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 6; i++) mSh[i] = 8'h00;
        mCnt    = 8'd0;
        pipe1   = {8'h00, 1'b1, 1'b1};
        outExp  = {8'h00, 1'b1, 1'b1};
        tickExp = 1'b0;
    endtask

    // Expected colour of one pixel, worked out from the text layout: 128x32 px
    // rows of eight 16x32 cells at X0=256, time row at y=192, date row at y=256.
    function automatic logic [7:0] modelRgb(input int x, input int y);
        int  row, col, ch, bitc, field, fid, digit;
        bit  isDate;
        logic [7:0] v, glyph;
        logic [3:0] code;
        if (x >= 640 || y >= 480) return 8'h00;
        if (x >= 256 && x < 384 && y >= 192 && y < 224) begin
            isDate = 1'b0; row = y - 192;
        end else if (x >= 256 && x < 384 && y >= 256 && y < 288) begin
            isDate = 1'b1; row = y - 256;
        end else begin
            return 8'h03;
        end
        col  = x - 256;
        ch   = col / 16;
        bitc = (col % 16) / 2;
        if (ch == 2 || ch == 5) begin
            code = isDate ? 4'd11 : 4'd10;
        end else begin
            field = ch / 3;
            v     = mSh[(isDate ? 3 : 0) + field];
            digit = (ch % 3 == 0) ? int'(v) / 16 : int'(v) % 16;
            fid   = (isDate ? 4 : 1) + field;
            if (digit > 9 || (int'(edit_sel) == fid && mCnt[5] == 1'b0)) code = 4'd12;
            else code = 4'(digit);
        end
        glyph = font_row(code, 4'(row / 2));
        return glyph[7 - bitc] ? 8'hFF : 8'h03;
    endfunction

    // One clock: present inputs, advance the model at the edge, check all outputs.
    task automatic applyStimulus(input logic en, input logic [9:0] x, input logic [9:0] y,
                                 input logic hs, input logic vs);
        px_en = en; px_x = x; px_y = y; hsync_in = hs; vsync_in = vs;
        @(posedge clk);
        if (!rst) begin
            modelReset();
        end else begin
            tickExp = en && (x == 10'd0) && (y == 10'd480);
            if (en) begin
                outExp = pipe1;
                pipe1  = {modelRgb(int'(x), int'(y)), hs, vs};
            end
            if (tickExp) begin
                mSh[0] = hh; mSh[1] = mm; mSh[2] = ss;
                mSh[3] = dd; mSh[4] = mo; mSh[5] = yy;
                mCnt   = mCnt + 8'd1;
            end
        end
        #1;
        checkOutput("rgb", {24'd0, rgb}, {24'd0, outExp[9:2]});
        checkOutput("hsync_out", {31'd0, hsync_out}, {31'd0, outExp[1]});
        checkOutput("vsync_out", {31'd0, vsync_out}, {31'd0, outExp[0]});
        checkOutput("frame_tick", {31'd0, frame_tick}, {31'd0, tickExp});
    endtask

    task automatic frameStart();
        applyStimulus(1'b1, 10'd0, 10'd480, 1'b1, 1'b1);
    endtask

    // Every pixel of a text row plus a two-pixel margin on each side.
    task automatic scanRow(input int y0);
        for (int dy = 0; dy < 32; dy++) begin
            for (int x = 254; x < 386; x++) begin
                applyStimulus(1'b1, 10'(x), 10'(y0 + dy), 1'($urandom_range(0, 1)), 1'b1);
            end
        end
    endtask

    task automatic randomBcd();
        hh = 8'($urandom_range(0, 255)); mm = 8'($urandom_range(0, 255));
        ss = 8'($urandom_range(0, 255)); dd = 8'($urandom_range(0, 255));
        mo = 8'($urandom_range(0, 255)); yy = 8'($urandom_range(0, 255));
    endtask

    // Reset asserted between clock edges must clear outputs without waiting for clk.
    task automatic pulseReset();
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rgb", {24'd0, rgb}, 32'd0);
        checkOutput("async_hsync", {31'd0, hsync_out}, 32'd1);
        checkOutput("async_vsync", {31'd0, vsync_out}, 32'd1);
        checkOutput("async_tick", {31'd0, frame_tick}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 10'($urandom_range(0, 799)), 10'($urandom_range(0, 524)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rst = 1'b1;
    endtask

    initial begin
        modelReset();
        // Reset held for five clocks mid-line.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 10'(100 + i), 10'd200, 1'($urandom_range(0, 1)), 1'b0);
        end
        rst = 1'b1;

        // 12:34:56 on 31/12/99, no editing.
        hh = 8'h12; mm = 8'h34; ss = 8'h56; dd = 8'h31; mo = 8'h12; yy = 8'h99;
        frameStart();
        applyStimulus(1'b0, 10'd1, 10'd480, 1'b1, 1'b1);
        scanRow(192);
        scanRow(256);

        // Tearing: hh changes mid-frame, display keeps the old value until next frame.
        applyStimulus(1'b1, 10'd5, 10'd100, 1'b1, 1'b1);
        hh = 8'h23;
        scanRow(192);
        frameStart();
        scanRow(192);

        // Invalid BCD low digit in the minutes field.
        mm = 8'h3A;
        frameStart();
        scanRow(192);

        // Blink hh over 64 frames, sampling both rows each frame.
        edit_sel = 3'd1;
        for (int f = 0; f < 64; f++) begin
            frameStart();
            for (int i = 0; i < 40; i++) begin
                applyStimulus(1'b1, 10'($urandom_range(256, 383)),
                              10'((i % 2 == 0) ? $urandom_range(192, 223) : $urandom_range(256, 287)),
                              1'b1, 1'b1);
            end
        end

        // Sync latency with a falling hsync, blanking region, then a strobe-less stretch.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 10'(640 + i), 10'd300, (i < 3), 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 10'($urandom_range(640, 799)), 10'd300, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 10'($urandom_range(0, 799)), 10'd200,
                                                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Randomised traffic with occasional frame starts, edit changes and a mid-run reset.
        for (int i = 0; i < 20000; i++) begin
            logic [9:0] x, y;
            if (i == 10000) pulseReset();
            if (i % 200 == 0) edit_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 399) == 0) begin
                randomBcd();
                frameStart();
            end else begin
                if ($urandom_range(0, 1) == 0) begin
                    x = 10'($urandom_range(250, 390));
                    y = 10'($urandom_range(186, 295));
                end else begin
                    x = 10'($urandom_range(0, 799));
                    y = 10'($urandom_range(0, 524));
                end
                applyStimulus(($urandom_range(0, 3) != 0), x, y,
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
